// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: N producer channels in, one consumer out.
// slave is the arbiter's view, master is the producer/consumer side.
interface mux_arb_reg_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode_rr;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  modport slave (
    input  in_data, in_valid, mode_rr, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, mode_rr, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_arb_reg.sv
// N-channel registered mux with fixed-select or round-robin arbitration,
// one-cycle latency and full-throughput valid/ready on every port.
module mux_arb_reg #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_arb_reg_if.slave   bus
);
  localparam int SELW = $clog2(NCH);

  logic [SELW-1:0]  r_rr_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_ch;

  logic             w_can_load;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_gnt;
  logic             w_fix_vld;
  logic             w_sel_vld;
  logic [SELW-1:0]  w_sel;
  logic [WIDTH-1:0] w_sel_data;
  logic [NCH-1:0]   w_in_ready;
  logic             w_load;
  logic [SELW-1:0]  w_rr_next;

  assign w_can_load = !r_out_valid || bus.out_ready;

  // Two-pass scan: channels at/after the pointer first, then the wrapped ones,
  // so the wrap point is NCH rather than 2**SELW.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_gnt = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!w_rr_vld && bus.in_valid[k] && (SELW'(k) >= r_rr_ptr)) begin
        w_rr_vld = 1'b1;
        w_rr_gnt = SELW'(k);
      end
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!w_rr_vld && bus.in_valid[k] && (SELW'(k) < r_rr_ptr)) begin
        w_rr_vld = 1'b1;
        w_rr_gnt = SELW'(k);
      end
    end
  end

  always_comb begin
    w_fix_vld = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (SELW'(k) == bus.sel) begin
        w_fix_vld = 1'b1;
      end
    end
  end

  assign w_sel_vld = bus.mode_rr ? w_rr_vld : w_fix_vld;
  assign w_sel     = bus.mode_rr ? w_rr_gnt : bus.sel;

  always_comb begin
    w_sel_data = '0;
    w_in_ready = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (SELW'(k) == w_sel) begin
        w_sel_data    = bus.in_data[k*WIDTH +: WIDTH];
        w_in_ready[k] = rst_n && w_can_load && w_sel_vld;
      end
    end
  end

  assign w_load    = |(w_in_ready & bus.in_valid);
  assign w_rr_next = (w_sel == SELW'(NCH - 1)) ? '0 : w_sel + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_sel;
      r_out_valid <= 1'b1;
      if (bus.mode_rr) begin
        r_rr_ptr <= w_rr_next;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
endmodule
